// File: rtl/wheel_integrator_pkg.sv
// Shared physics types: integrator FSM state encoding and a signed saturation helper.
package physics_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GATHER    = 2'd1,
        INTEGRATE = 2'd2,
        DONE      = 2'd3
    } integ_state_t;

    // Clamp a wide signed value into the range of a w-bit signed number.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                      input int unsigned        w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/node_integrator.sv
// One axis of one node: sums the accepted forces plus gravity, scales by mass,
// then performs a saturated semi-implicit Euler update (position uses new velocity).
module node_integrator
    import physics_pkg::*;
#(
    parameter int          NUM_SOURCES   = 4,
    parameter int          FORCE_SIZE    = 16,
    parameter int          POSITION_SIZE = 16,
    parameter int          VELOCITY_SIZE = 16,
    parameter int          GRAV          = 0,
    parameter int          MASS_SHIFT    = 0,
    parameter int unsigned DT            = 1
) (
    input  logic signed [FORCE_SIZE-1:0]    force_i [NUM_SOURCES],
    input  logic        [NUM_SOURCES-1:0]   en_i,
    input  logic signed [POSITION_SIZE-1:0] pos_i,
    input  logic signed [VELOCITY_SIZE-1:0] vel_i,
    output logic signed [POSITION_SIZE-1:0] pos_o,
    output logic signed [VELOCITY_SIZE-1:0] vel_o
);

    // Wide enough that the sum of every source plus gravity can never wrap.
    localparam int SUM_W = FORCE_SIZE + $clog2(NUM_SOURCES + 1) + 1;
    localparam logic signed [63:0] DT_S = 64'(DT);

    logic signed [SUM_W-1:0] f_sum;
    logic signed [SUM_W-1:0] accel;
    logic signed [63:0]      v_new;
    logic signed [63:0]      p_new;

    // Force sum, mass scaling and saturated velocity/position update.
    always_comb begin
        f_sum = SUM_W'(GRAV);
        for (int unsigned s = 0; s < NUM_SOURCES; s++) begin
            if (en_i[s]) begin
                f_sum = f_sum + SUM_W'(force_i[s]);
            end
        end
        accel = f_sum >>> MASS_SHIFT;
        v_new = sat_signed(64'(vel_i) + 64'(accel) * DT_S, VELOCITY_SIZE);
        p_new = sat_signed(64'(pos_i) + v_new * DT_S, POSITION_SIZE);
        vel_o = VELOCITY_SIZE'(v_new);
        pos_o = POSITION_SIZE'(p_new);
    end

endmodule

// File: rtl/wheel_integrator.sv
// Wheel integration core: gathers force vectors from the force units, then integrates
// velocity and position for every node of every wheel, one node per cycle.
module wheel_integrator
    import physics_pkg::*;
#(
    parameter int          NUM_WHEELS    = 2,
    parameter int          NUM_NODES     = 10,
    parameter int          NUM_SOURCES   = 4,
    parameter int          POSITION_SIZE = 16,
    parameter int          VELOCITY_SIZE = 16,
    parameter int          FORCE_SIZE    = 16,
    parameter int          GRAVITY       = -1,
    parameter int          MASS_SHIFT    = 0,
    parameter int unsigned DT            = 1,
    parameter int unsigned TIMEOUT       = 255
) (
    input  logic                            clk_in,
    input  logic                            rst_n_in,
    input  logic                            begin_in,
    input  logic        [NUM_SOURCES-1:0]   source_mask_in,
    input  logic        [NUM_SOURCES-1:0]   source_valid_in,
    input  logic signed [FORCE_SIZE-1:0]    forces_in      [NUM_SOURCES][2][NUM_WHEELS*NUM_NODES],
    input  logic signed [POSITION_SIZE-1:0] nodes_in       [2][NUM_WHEELS*NUM_NODES],
    input  logic signed [VELOCITY_SIZE-1:0] velocities_in  [2][NUM_WHEELS*NUM_NODES],
    output logic signed [POSITION_SIZE-1:0] nodes_out      [2][NUM_WHEELS*NUM_NODES],
    output logic signed [VELOCITY_SIZE-1:0] velocities_out [2][NUM_WHEELS*NUM_NODES],
    output logic                            busy_out,
    output logic                            timeout_out,
    output logic                            result_out
);

    localparam int NT = NUM_WHEELS * NUM_NODES;
    localparam int KW = (NT > 1) ? $clog2(NT) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    integ_state_t                    state_q, state_d;
    logic        [NUM_SOURCES-1:0]   mask_q;
    logic        [NUM_SOURCES-1:0]   got_q;
    logic        [TW-1:0]            timer_q;
    logic        [KW-1:0]            k_q;
    logic                            timeout_q;
    logic                            result_q;
    logic signed [FORCE_SIZE-1:0]    cap_q [NUM_SOURCES][2][NT];
    logic signed [POSITION_SIZE-1:0] pos_q [2][NT];
    logic signed [VELOCITY_SIZE-1:0] vel_q [2][NT];

    logic                            complete;
    logic                            last_node;
    logic signed [FORCE_SIZE-1:0]    sel_f [2][NUM_SOURCES];
    logic signed [POSITION_SIZE-1:0] new_p [2];
    logic signed [VELOCITY_SIZE-1:0] new_v [2];

    assign complete    = ((got_q & mask_q) == mask_q);
    assign last_node   = (k_q == KW'(NT - 1));
    assign busy_out    = (state_q != IDLE);
    assign timeout_out = timeout_q;
    assign result_out  = result_q;

    // Step sequencing: wait for begin, gather until complete or timed out, sweep nodes, report.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (begin_in) state_d = GATHER;
            GATHER:    if (complete || (timer_q == TW'(TIMEOUT - 1))) state_d = INTEGRATE;
            INTEGRATE: if (last_node) state_d = DONE;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Route the captured forces of the current node to the per-axis integrators.
    always_comb begin
        for (int unsigned a = 0; a < 2; a++) begin
            for (int unsigned s = 0; s < NUM_SOURCES; s++) begin
                sel_f[a][s] = cap_q[s][a][k_q];
            end
        end
    end

    for (genvar a = 0; a < 2; a++) begin : g_axis
        node_integrator #(
            .NUM_SOURCES  (NUM_SOURCES),
            .FORCE_SIZE   (FORCE_SIZE),
            .POSITION_SIZE(POSITION_SIZE),
            .VELOCITY_SIZE(VELOCITY_SIZE),
            .GRAV         ((a == 1) ? GRAVITY : 0),
            .MASS_SHIFT   (MASS_SHIFT),
            .DT           (DT)
        ) u_node (
            .force_i(sel_f[a]),
            .en_i   (got_q & mask_q),
            .pos_i  (pos_q[a][k_q]),
            .vel_i  (vel_q[a][k_q]),
            .pos_o  (new_p[a]),
            .vel_o  (new_v[a])
        );
    end

    // State, capture registers, counters and integrated outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            got_q     <= '0;
            timer_q   <= '0;
            k_q       <= '0;
            timeout_q <= 1'b0;
            result_q  <= 1'b0;
            for (int unsigned a = 0; a < 2; a++) begin
                for (int unsigned k = 0; k < NT; k++) begin
                    pos_q[a][k]          <= '0;
                    vel_q[a][k]          <= '0;
                    nodes_out[a][k]      <= '0;
                    velocities_out[a][k] <= '0;
                    for (int unsigned s = 0; s < NUM_SOURCES; s++) begin
                        cap_q[s][a][k] <= '0;
                    end
                end
            end
        end else begin
            state_q  <= state_d;
            result_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (begin_in) begin
                        pos_q     <= nodes_in;
                        vel_q     <= velocities_in;
                        mask_q    <= source_mask_in;
                        got_q     <= '0;
                        timer_q   <= '0;
                        k_q       <= '0;
                        timeout_q <= 1'b0;
                    end
                end
                GATHER: begin
                    timer_q <= timer_q + 1'b1;
                    for (int unsigned s = 0; s < NUM_SOURCES; s++) begin
                        if (source_valid_in[s] && mask_q[s]) begin
                            cap_q[s]  <= forces_in[s];
                            got_q[s]  <= 1'b1;
                        end
                    end
                end
                INTEGRATE: begin
                    for (int unsigned a = 0; a < 2; a++) begin
                        nodes_out[a][k_q]      <= new_p[a];
                        velocities_out[a][k_q] <= new_v[a];
                    end
                    if (last_node) begin
                        k_q       <= '0;
                        result_q  <= 1'b1;
                        timeout_q <= ((got_q & mask_q) != mask_q);
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wheel_integrator.sv
// Scoreboard bench for wheel_integrator: stimulus pushes hand-computed results,
// a negedge monitor pops and compares whenever result_out pulses.
module tb_wheel_integrator;

    localparam int NS = 4;
    localparam int NT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              begin_in;
    logic [NS-1:0]     source_mask_in;
    logic [NS-1:0]     source_valid_in;
    logic signed [15:0] forces_in      [NS][2][NT];
    logic signed [15:0] nodes_in       [2][NT];
    logic signed [15:0] velocities_in  [2][NT];
    logic signed [15:0] nodes_out      [2][NT];
    logic signed [15:0] velocities_out [2][NT];
    logic              busy_out;
    logic              timeout_out;
    logic              result_out;

    wheel_integrator #(
        .NUM_WHEELS(1), .NUM_NODES(2), .NUM_SOURCES(NS),
        .POSITION_SIZE(16), .VELOCITY_SIZE(16), .FORCE_SIZE(16),
        .GRAVITY(-1), .MASS_SHIFT(1), .DT(1), .TIMEOUT(8)
    ) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .begin_in       (begin_in),
        .source_mask_in (source_mask_in),
        .source_valid_in(source_valid_in),
        .forces_in      (forces_in),
        .nodes_in       (nodes_in),
        .velocities_in  (velocities_in),
        .nodes_out      (nodes_out),
        .velocities_out (velocities_out),
        .busy_out       (busy_out),
        .timeout_out    (timeout_out),
        .result_out     (result_out)
    );

    typedef struct packed {
        logic [3:0][15:0] p;
        logic [3:0][15:0] v;
        logic             to;
        logic [31:0]      cyc;
        logic [7:0]       id;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int bcyc   = 0;
    int ep[2][NT];
    int ev[2][NT];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Monitor: every result pulse is matched against the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && result_out) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got result_out=1, expected no pending step");
            end else begin
                e = sb.pop_front();
                for (int a = 0; a < 2; a++) begin
                    for (int k = 0; k < NT; k++) begin
                        chk($sformatf("step%0d pos[%0d][%0d]", e.id, a, k),
                            int'(nodes_out[a][k]), int'($signed(e.p[a*NT+k])));
                        chk($sformatf("step%0d vel[%0d][%0d]", e.id, a, k),
                            int'(velocities_out[a][k]), int'($signed(e.v[a*NT+k])));
                    end
                end
                chk($sformatf("step%0d timeout", e.id), int'(timeout_out), int'(e.to));
                chk($sformatf("step%0d result_cycle", e.id), cyc, int'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [NS-1:0] m);
        source_mask_in = m;
        begin_in = 1'b1;
        tick();
        begin_in = 1'b0;
        bcyc = cyc;
    endtask

    task automatic pulse(input logic [NS-1:0] vm);
        source_valid_in = vm;
        tick();
        source_valid_in = '0;
    endtask

    task automatic set_node(input int k, input int px, input int py, input int vx, input int vy);
        nodes_in[0][k] = 16'(px);
        nodes_in[1][k] = 16'(py);
        velocities_in[0][k] = 16'(vx);
        velocities_in[1][k] = 16'(vy);
    endtask

    task automatic set_force(input int s, input int k, input int fx, input int fy);
        forces_in[s][0][k] = 16'(fx);
        forces_in[s][1][k] = 16'(fy);
    endtask

    task automatic clear_forces();
        for (int s = 0; s < NS; s++)
            for (int k = 0; k < NT; k++)
                set_force(s, k, 0, 0);
    endtask

    task automatic set_exp(input int k, input int px, input int py, input int vx, input int vy);
        ep[0][k] = px;
        ep[1][k] = py;
        ev[0][k] = vx;
        ev[1][k] = vy;
    endtask

    // g = number of GATHER cycles; result expected g+NT cycles after begin is sampled.
    task automatic push_exp(input int id, input int g, input bit to);
        exp_t e;
        e.id  = 8'(id);
        e.to  = to;
        e.cyc = 32'(bcyc + g + NT);
        for (int a = 0; a < 2; a++) begin
            for (int k = 0; k < NT; k++) begin
                e.p[a*NT+k] = 16'(ep[a][k]);
                e.v[a*NT+k] = 16'(ev[a][k]);
            end
        end
        sb.push_back(e);
    endtask

    task automatic wait_result(input string name);
        int n;
        n = 0;
        while (!result_out && n < 40) begin
            tick();
            n++;
        end
        if (!result_out) begin
            checks++;
            errors++;
            $display("FAIL %s_wait: got no result_out within 40 cycles, expected a result", name);
        end else begin
            tick();
        end
    endtask

    task automatic chk_all_zero(input string name);
        for (int a = 0; a < 2; a++) begin
            for (int k = 0; k < NT; k++) begin
                chk($sformatf("%s pos[%0d][%0d]", name, a, k), int'(nodes_out[a][k]), 0);
                chk($sformatf("%s vel[%0d][%0d]", name, a, k), int'(velocities_out[a][k]), 0);
            end
        end
        chk({name, " busy"}, int'(busy_out), 0);
        chk({name, " result"}, int'(result_out), 0);
        chk({name, " timeout"}, int'(timeout_out), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1;
        begin_in = 1'b0;
        source_mask_in = '0;
        source_valid_in = '0;
        clear_forces();
        for (int k = 0; k < NT; k++) set_node(k, 0, 0, 0, 0);
        #3 rst_n = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Step 1: no sources, gravity only.
        start('0);
        set_exp(0, 0, -1, 0, -1);
        set_exp(1, 0, -1, 0, -1);
        push_exp(1, 1, 1'b0);
        wait_result("step1");

        // Step 2: two masked sources, a repeated pulse, an unmasked pulse.
        set_node(0, 10, 20, 1, 2);
        set_node(1, -5, -6, 0, 0);
        start(4'b0011);
        set_exp(0, 14, 20, 4, 0);
        set_exp(1, -1, -8, 4, -2);
        push_exp(2, 5, 1'b0);
        set_force(1, 0, 100, 100);
        set_force(1, 1, 100, 100);
        pulse(4'b0010);
        set_force(1, 0, 2, -2);
        set_force(1, 1, 0, -4);
        set_force(2, 0, 1000, 1000);
        set_force(2, 1, 1000, 1000);
        pulse(4'b0110);
        tick();
        set_force(0, 0, 4, 0);
        set_force(0, 1, 8, 2);
        pulse(4'b0001);
        wait_result("step2");
        tick();
        tick();
        chk("hold pos[1][1]", int'(nodes_out[1][1]), -8);
        chk("hold vel[0][0]", int'(velocities_out[0][0]), 4);

        // Step 3: saturation at both rails.
        clear_forces();
        set_node(0, 32760, 0, 32700, 0);
        set_node(1, -32760, 0, -32700, 0);
        set_force(0, 0, 1000, 0);
        set_force(0, 1, -1000, 0);
        start(4'b0001);
        set_exp(0, 32767, -1, 32767, -1);
        set_exp(1, -32768, -1, -32768, -1);
        push_exp(3, 2, 1'b0);
        pulse(4'b0001);
        wait_result("step3");

        // Step 4: src2 never arrives in GATHER (its begin-cycle pulse is ignored) -> timeout.
        clear_forces();
        for (int k = 0; k < NT; k++) begin
            set_node(k, 0, 0, 0, 0);
            set_force(0, k, 2, 2);
            set_force(2, k, 50, 50);
        end
        source_valid_in = 4'b0100;
        start(4'b0101);
        source_valid_in = '0;
        tick();
        pulse(4'b0001);
        set_exp(0, 1, 0, 1, 0);
        set_exp(1, 1, 0, 1, 0);
        push_exp(4, 8, 1'b1);
        wait_result("step4");

        // Step 6: begin held high while busy, input changes and source pulses during INTEGRATE.
        clear_forces();
        for (int k = 0; k < NT; k++) set_force(0, k, 3, 5);
        source_mask_in = 4'b0001;
        begin_in = 1'b1;
        tick();
        bcyc = cyc;
        for (int k = 0; k < NT; k++) set_node(k, 77, 77, 77, 77);
        pulse(4'b0001);
        set_exp(0, 1, 2, 1, 2);
        set_exp(1, 1, 2, 1, 2);
        push_exp(6, 2, 1'b0);
        tick();
        for (int k = 0; k < NT; k++) set_force(0, k, 100, 100);
        source_valid_in = 4'b0001;
        tick();
        tick();
        source_valid_in = '0;
        begin_in = 1'b0;
        wait_result("step6");
        chk("step6 busy_after", int'(busy_out), 0);

        // Step 5: reset in the middle of INTEGRATE, then a clean step.
        clear_forces();
        for (int k = 0; k < NT; k++) set_node(k, 3, 4, 1, 1);
        start('0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        tick();
        rst_n = 1'b1;
        tick();
        start('0);
        set_exp(0, 4, 4, 1, 0);
        set_exp(1, 4, 4, 1, 0);
        push_exp(5, 1, 1'b0);
        wait_result("step5");

        tick();
        tick();
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
